// File: rtl/ahb_sram_if.sv
// rtl/ahb_sram_if.sv - AHB-Lite slave-port signal bundle
interface ahb_sram_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_responder.sv
// rtl/ahb_sram_responder.sv - AHB-Lite SRAM slave with read wait states and two-cycle ERROR
module ahb_sram_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int RD_WAIT    = 1
) (
  input  logic      HCLK,
  input  logic      HRESET,
  ahb_sram_if.slave bus
);
  localparam int IW    = ADDR_WIDTH - 2;
  localparam int WORDS = 2 ** IW;
  localparam logic [2:0] WAIT_LOAD = (RD_WAIT > 0) ? 3'(RD_WAIT - 1) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_RDWAIT, S_ERR1, S_ERR2} state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    size_q, size_d;
  logic          write_q, write_d;
  logic          wr_pend_q, wr_pend_d;
  logic          rd_pend_q, rd_pend_d;

  logic [31:0]   mem [WORDS];
  logic          ready;
  logic          accept;
  logic          illegal;
  logic [3:0]    lanes;

  assign ready   = (state_q == S_IDLE) || (state_q == S_ERR2);
  assign accept  = ready && bus.HSEL && bus.HREADY && (bus.HTRANS inside {2'b10, 2'b11});
  assign illegal = (bus.HSIZE > 3'd2)
                || ((bus.HSIZE == 3'd1) && bus.HADDR[0])
                || ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00))
                || (bus.HADDR[31:ADDR_WIDTH] != '0);

  assign bus.HREADYOUT = ready;
  assign bus.HRESP     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01 : 2'b00;
  // Array is read in the data phase so a write committed on the accepting edge is visible.
  assign bus.HRDATA    = ((state_q == S_IDLE) && rd_pend_q) ? mem[idx_q] : 32'h0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    off_d     = off_q;
    size_d    = size_q;
    write_d   = write_q;
    wr_pend_d = 1'b0;
    rd_pend_d = 1'b0;
    case (state_q)
      S_IDLE, S_ERR2: begin
        state_d = S_IDLE;
        if (accept) begin
          idx_d   = bus.HADDR[ADDR_WIDTH-1:2];
          off_d   = bus.HADDR[1:0];
          size_d  = bus.HSIZE;
          write_d = bus.HWRITE;
          if (illegal) begin
            state_d = S_ERR1;
          end else if (bus.HWRITE) begin
            wr_pend_d = 1'b1;
          end else begin
            rd_pend_d = 1'b1;
            if (RD_WAIT > 0) begin
              state_d = S_RDWAIT;
              cnt_d   = WAIT_LOAD;
            end
          end
        end
      end
      S_RDWAIT: begin
        rd_pend_d = 1'b1;
        if (cnt_q == 3'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      idx_q     <= '0;
      off_q     <= 2'b00;
      size_q    <= 3'd0;
      write_q   <= 1'b0;
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      off_q     <= off_d;
      size_q    <= size_d;
      write_q   <= write_d;
      wr_pend_q <= wr_pend_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  always_comb begin
    lanes = 4'b0000;
    case (size_q)
      3'd0:    lanes[off_q] = 1'b1;
      3'd1:    lanes = off_q[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (wr_pend_q) begin
      for (int b = 0; b < 4; b++) begin
        if (lanes[b]) mem[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_ahb_sram_responder.sv
// tb/tb_ahb_sram_responder.sv - directed self-checking bench for ahb_sram_responder
module tb_ahb_sram_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ext_block = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  ahb_sram_if bus();
  assign bus.HREADY = ext_block ? 1'b0 : bus.HREADYOUT;

  ahb_sram_responder #(.ADDR_WIDTH(12), .RD_WAIT(1)) dut (
    .HCLK(clk), .HRESET(rst), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic sel, input logic [1:0] trans, input logic wr,
                          input logic [2:0] size, input logic [31:0] addr);
    bus.HSEL = sel; bus.HTRANS = trans; bus.HWRITE = wr; bus.HSIZE = size; bus.HADDR = addr;
  endtask

  task automatic xfer(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, output int waits, output logic [31:0] rdata,
                      output logic [1:0] resp_first, output logic [1:0] resp_last);
    set_addr(1'b1, 2'b10, wr, size, addr);
    cycle();
    set_addr(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
    bus.HWDATA = wdata;
    waits = 0;
    resp_first = bus.HRESP;
    while (!bus.HREADYOUT && waits < 20) begin
      waits++;
      cycle();
    end
    rdata = bus.HRDATA;
    resp_last = bus.HRESP;
    cycle();
  endtask

  task automatic test_reset();
    n_checks++; if (bus.HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout: got %b want 1", bus.HREADYOUT); end
    n_checks++; if (bus.HRESP !== 2'b00) begin n_fail++; $display("FAIL reset_hresp: got %b want 00", bus.HRESP); end
    n_checks++; if (bus.HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata: got %h want 0", bus.HRDATA); end
  endtask

  task automatic test_word_rw();
    int w; logic [31:0] d; logic [1:0] r0, r1;
    xfer(1'b1, 3'd2, 32'h010, 32'hDEADBEEF, w, d, r0, r1);
    n_checks++; if (w !== 0 || r1 !== 2'b00) begin n_fail++; $display("FAIL word_write_phase: waits %0d resp %b want 0 00", w, r1); end
    xfer(1'b0, 3'd2, 32'h010, 32'h0, w, d, r0, r1);
    n_checks++; if (w !== 1) begin n_fail++; $display("FAIL word_read_waits: got %0d want 1", w); end
    n_checks++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_read_data: got %h want deadbeef", d); end
    n_checks++; if (r1 !== 2'b00) begin n_fail++; $display("FAIL word_read_resp: got %b want 00", r1); end
    n_checks++; if (bus.HRDATA !== 32'h0) begin n_fail++; $display("FAIL hrdata_after_read: got %h want 0", bus.HRDATA); end
  endtask

  task automatic test_byte_half();
    int w; logic [31:0] d; logic [1:0] r0, r1;
    xfer(1'b1, 3'd2, 32'h010, 32'h11223344, w, d, r0, r1);
    xfer(1'b1, 3'd0, 32'h013, 32'hAA998877, w, d, r0, r1);
    xfer(1'b0, 3'd2, 32'h010, 32'h0, w, d, r0, r1);
    n_checks++; if (d !== 32'hAA223344) begin n_fail++; $display("FAIL byte_write: got %h want aa223344", d); end
    xfer(1'b1, 3'd1, 32'h010, 32'h77775566, w, d, r0, r1);
    xfer(1'b0, 3'd2, 32'h010, 32'h0, w, d, r0, r1);
    n_checks++; if (d !== 32'hAA225566) begin n_fail++; $display("FAIL half_write: got %h want aa225566", d); end
  endtask

  task automatic test_back_to_back();
    int w;
    set_addr(1'b1, 2'b10, 1'b1, 3'd2, 32'h020);
    cycle();
    bus.HWDATA = 32'h12345678;
    set_addr(1'b1, 2'b10, 1'b0, 3'd2, 32'h020);
    n_checks++; if (bus.HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL b2b_write_ready: got %b want 1", bus.HREADYOUT); end
    cycle();
    set_addr(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
    w = 0;
    while (!bus.HREADYOUT && w < 20) begin w++; cycle(); end
    n_checks++; if (w !== 1) begin n_fail++; $display("FAIL b2b_read_waits: got %0d want 1", w); end
    n_checks++; if (bus.HRDATA !== 32'h12345678) begin n_fail++; $display("FAIL b2b_read_data: got %h want 12345678", bus.HRDATA); end
    cycle();
  endtask

  task automatic test_errors();
    logic [31:0] addrs [4];
    logic [2:0]  sizes [4];
    int w; logic [31:0] d; logic [1:0] r0, r1;
    addrs = '{32'h002, 32'h1000, 32'h011, 32'h010};
    sizes = '{3'd2, 3'd2, 3'd1, 3'd3};
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, sizes[i], addrs[i], 32'h0, w, d, r0, r1);
      n_checks++;
      if (w !== 1 || r0 !== 2'b01 || r1 !== 2'b01 || d !== 32'h0) begin
        n_fail++; $display("FAIL err_case%0d: waits %0d resp %b/%b data %h want 1 01/01 0", i, w, r0, r1, d);
      end
    end
    xfer(1'b1, 3'd2, 32'h1010, 32'hFFFFFFFF, w, d, r0, r1);
    n_checks++; if (r1 !== 2'b01) begin n_fail++; $display("FAIL err_write_resp: got %b want 01", r1); end
    xfer(1'b0, 3'd2, 32'h010, 32'h0, w, d, r0, r1);
    n_checks++; if (d !== 32'hAA225566) begin n_fail++; $display("FAIL err_write_ram: got %h want aa225566", d); end
  endtask

  task automatic test_no_accept();
    logic       sels   [3];
    logic [1:0] trans  [3];
    int w; logic [31:0] d; logic [1:0] r0, r1;
    sels  = '{1'b1, 1'b1, 1'b0};
    trans = '{2'b00, 2'b01, 2'b10};
    for (int i = 0; i < 3; i++) begin
      set_addr(sels[i], trans[i], 1'b0, 3'd2, 32'h010);
      cycle();
      set_addr(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
      n_checks++;
      if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 2'b00 || bus.HRDATA !== 32'h0) begin
        n_fail++; $display("FAIL no_accept%0d: ready %b resp %b data %h want 1 00 0", i, bus.HREADYOUT, bus.HRESP, bus.HRDATA);
      end
    end
    ext_block = 1'b1;
    set_addr(1'b1, 2'b10, 1'b0, 3'd2, 32'h010);
    cycle();
    set_addr(1'b1, 2'b10, 1'b1, 3'd2, 32'h010);
    n_checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRDATA !== 32'h0) begin n_fail++; $display("FAIL hready_block_read: ready %b data %h want 1 0", bus.HREADYOUT, bus.HRDATA); end
    cycle();
    bus.HWDATA = 32'h0;
    set_addr(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
    ext_block = 1'b0;
    cycle();
    xfer(1'b0, 3'd2, 32'h010, 32'h0, w, d, r0, r1);
    n_checks++; if (d !== 32'hAA225566) begin n_fail++; $display("FAIL hready_block_write: got %h want aa225566", d); end
  endtask

  task automatic test_reset_mid();
    int w; logic [31:0] d; logic [1:0] r0, r1;
    set_addr(1'b1, 2'b10, 1'b0, 3'd2, 32'h010);
    cycle();
    set_addr(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
    n_checks++; if (bus.HREADYOUT !== 1'b0) begin n_fail++; $display("FAIL rdwait_entered: got %b want 0", bus.HREADYOUT); end
    rst = 1'b1; #1;
    n_checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 2'b00 || bus.HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_in_rdwait: ready %b resp %b data %h want 1 00 0", bus.HREADYOUT, bus.HRESP, bus.HRDATA); end
    cycle(); rst = 1'b0;
    set_addr(1'b1, 2'b10, 1'b0, 3'd2, 32'h002);
    cycle();
    set_addr(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
    n_checks++; if (bus.HREADYOUT !== 1'b0 || bus.HRESP !== 2'b01) begin n_fail++; $display("FAIL err1_entered: ready %b resp %b want 0 01", bus.HREADYOUT, bus.HRESP); end
    rst = 1'b1; #1;
    n_checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 2'b00 || bus.HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_in_err1: ready %b resp %b data %h want 1 00 0", bus.HREADYOUT, bus.HRESP, bus.HRDATA); end
    cycle(); rst = 1'b0;
    set_addr(1'b1, 2'b10, 1'b1, 3'd2, 32'h010);
    cycle();
    set_addr(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
    bus.HWDATA = 32'h0BADF00D;
    rst = 1'b1; #1;
    cycle(); rst = 1'b0;
    xfer(1'b0, 3'd2, 32'h010, 32'h0, w, d, r0, r1);
    n_checks++; if (d !== 32'hAA225566) begin n_fail++; $display("FAIL ram_after_reset_010: got %h want aa225566", d); end
    xfer(1'b0, 3'd2, 32'h020, 32'h0, w, d, r0, r1);
    n_checks++; if (d !== 32'h12345678) begin n_fail++; $display("FAIL ram_after_reset_020: got %h want 12345678", d); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    set_addr(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
    bus.HWDATA = 32'h0;
    repeat (2) cycle();
    test_reset();
    rst = 1'b0;
    cycle();
    test_word_rw();
    test_byte_half();
    test_back_to_back();
    test_errors();
    test_no_accept();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_sram_responder.md
Name: ahb_sram_responder

Overview:
- AHB-Lite responder (slave) placed behind one output port of the L1 AHB bus matrix, i.e. on the far end of a decoder's sel/HREADYOUT/HRESP/HRDATA path.
- Holds a word-organised on-chip RAM.
- Handles byte, halfword and word transfers, inserts programmable read wait states, and returns a two-cycle ERROR for illegal accesses.

Parameters:
- ADDR_WIDTH, 12, byte-address width of the RAM; size = 2^ADDR_WIDTH bytes, i.e. 2^(ADDR_WIDTH-2) 32-bit words.
- RD_WAIT, 1, wait states inserted on every read data phase (0..7).

Ports:
- HCLK  input  1  AHB system clock; all state on rising edge.
- HRESET  input  1  asynchronous, active-high reset.
- HSEL  input  1  slave select from decoder.
- HADDR  input  32  address phase byte address.
- HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  input  1  1 = write.
- HSIZE  input  3  000 byte, 001 halfword, 010 word; others illegal.
- HWDATA  input  32  write data, valid in the data phase.
- HREADY  input  1  bus-level transfer-done (matrix HREADYS).
- HREADYOUT  output  1  this slave's ready.
- HRESP  output  2  00 OKAY, 01 ERROR.
- HRDATA  output  32  read data.

Behaviour:
- Reset (HRESET=1, async): state IDLE, HREADYOUT=1, HRESP=00, HRDATA=0, wait counter 0, all latched address-phase registers 0. RAM contents are not reset.
- Reset mid-operation (wait or error state) aborts the transfer and returns to IDLE; no RAM write is committed for an aborted write.

Address phase:
- Accepted on a rising edge with HSEL & HREADY & HTRANS[1].
- On acceptance, latch word index HADDR[ADDR_WIDTH-1:2], HADDR[1:0], HSIZE and HWRITE.
- Not accepted (IDLE/BUSY, HSEL=0 or HREADY=0): the next data phase is zero-wait OKAY, HRDATA=0.

Legality check (made at acceptance):
- Illegal if HSIZE>2, or HADDR misaligned for HSIZE (halfword with HADDR[0]=1; word with HADDR[1:0]!=0), or HADDR[31:ADDR_WIDTH]!=0.

State machine (IDLE, RDWAIT, ERR1, ERR2):
- IDLE: HREADYOUT=1, HRESP=00.
  - Legal write accepted: stay IDLE. The data phase is zero-wait.
  - Legal read accepted: RDWAIT if RD_WAIT>0, else IDLE with data returned in the next cycle.
  - Illegal accept: ERR1.
- RDWAIT: HREADYOUT=0, HRESP=00. Counter loads RD_WAIT-1 on entry and decrements each cycle. Leave to IDLE at 0, completing the data phase with HREADYOUT=1 and HRDATA valid.
- ERR1: HREADYOUT=0, HRESP=01. Always goes to ERR2.
- ERR2: HREADYOUT=1, HRESP=01. Returns to IDLE. A new address phase presented in this cycle is accepted and evaluated normally.

Write commit:
- On the edge ending a legal write data phase, RAM[word] is updated using byte lanes from the latched HADDR[1:0]/HSIZE:
  - byte: lane HADDR[1:0];
  - halfword: lanes {HADDR[1],0} and {HADDR[1],1};
  - word: all four lanes.
- Unselected lanes are unchanged. Illegal writes never modify RAM.

Read data:
- HRDATA = full 32-bit RAM word of the latched index, driven only in the cycle the read data phase completes; 0 otherwise, including ERROR cycles. No byte-lane masking.
- Read-after-write to the same word in back-to-back transfers returns the newly written data, with no extra stall. The write commits on the same edge the read is accepted, and the read array access happens in the data phase.

Other rules:
- The address phase of the next transfer may overlap a write data phase or the last read cycle (pipelined AHB).
- HREADY low from another slave blocks acceptance.
- HSEL=0 during a pending data phase does not cancel that phase.

Test Plan:
- Word write 0xDEADBEEF to 0x010 then read 0x010, RD_WAIT=1: write data phase zero-wait OKAY. Read shows HREADYOUT=0 for 1 cycle, then HRDATA=0xDEADBEEF, HRESP=00.
- Byte write 0xAA to 0x013 over 0x11223344, then word read 0x010: returns 0xAA223344. Halfword write 0x5566 to 0x010 then read: returns 0xAA225566.
- Back-to-back NONSEQ write 0x12345678 @0x020 followed immediately by read @0x020: read returns 0x12345678 with exactly RD_WAIT wait cycles.
- Misaligned word read @0x002 and out-of-range @0x00001000 (ADDR_WIDTH=12): ERR1 (HREADYOUT=0, HRESP=01), then ERR2 (HREADYOUT=1, HRESP=01). An out-of-range write leaves RAM unchanged.
- IDLE/BUSY transfers, and HSEL=0 with HTRANS=NONSEQ: zero-wait OKAY, HRDATA=0. HREADY=0 from another slave holds off acceptance.
- Assert HRESET during RDWAIT and again during ERR1: outputs immediately HREADYOUT=1, HRESP=00, HRDATA=0. RAM keeps its prior contents.
